// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath.
interface multicycle_ctrl_if #(
  parameter int unsigned OP_W = 6,
  parameter int unsigned ST_W = 3
);
  logic [OP_W-1:0] instr_op_i;
  logic            zero_i;
  logic            mem_ack_i;
  logic            mem_req_o;
  logic            mem_we_o;
  logic            iord_o;
  logic            ir_write_o;
  logic            pc_write_o;
  logic [1:0]      pc_src_o;
  logic            keep_sign_o;
  logic [1:0]      alu_src_b_o;
  logic [2:0]      alu_op_o;
  logic            reg_dst_o;
  logic            mem_to_reg_o;
  logic            reg_write_o;
  logic            illegal_o;
  logic [ST_W-1:0] state_o;

  modport master (
    input  instr_op_i, zero_i, mem_ack_i,
    output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
           keep_sign_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
           reg_write_o, illegal_o, state_o
  );

  modport slave (
    output instr_op_i, zero_i, mem_ack_i,
    input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
           keep_sign_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
           reg_write_o, illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS-subset datapath (FETCH/DECODE/EXEC/MEM/WB).
// Owns the single shared memory port; one instruction in flight at a time.
module multicycle_ctrl #(
  parameter int unsigned OP_W = 6,
  parameter int unsigned ST_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);

  state_t          state, state_nx;
  logic [OP_W-1:0] op_q;
  logic            illegal_q;
  logic            illegal_set;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == DECODE) op_q <= bus.instr_op_i;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx         = state;
    illegal_set      = 1'b0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.iord_o       = 1'b0;
    bus.ir_write_o   = 1'b0;
    bus.pc_write_o   = 1'b0;
    bus.pc_src_o     = 2'd0;
    bus.keep_sign_o  = 1'b0;
    bus.alu_src_b_o  = 2'd0;
    bus.alu_op_o     = 3'd0;
    bus.reg_dst_o    = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.reg_write_o  = 1'b0;

    case (state)
      IDLE: state_nx = FETCH;

      FETCH: begin
        bus.mem_req_o   = 1'b1;
        bus.alu_src_b_o = 2'd1;
        if (bus.mem_ack_i) begin
          bus.ir_write_o = 1'b1;
          bus.pc_write_o = 1'b1;
          state_nx       = DECODE;
        end
      end

      // Opcode comes straight from IR here; op_q only becomes valid in EXEC.
      DECODE: begin
        bus.alu_src_b_o = 2'd3;
        bus.keep_sign_o = 1'b1;
        case (bus.instr_op_i)
          OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
          OP_ANDI, OP_ORI, OP_LW, OP_SW: state_nx = EXEC;
          default: begin
            state_nx    = HALT;
            illegal_set = 1'b1;
          end
        endcase
      end

      EXEC: begin
        state_nx = WB;
        case (op_q)
          OP_R: bus.alu_op_o = 3'd2;
          OP_ADDI, OP_LW, OP_SW: begin
            bus.alu_src_b_o = 2'd2;
            bus.keep_sign_o = 1'b1;
            if (op_q != OP_ADDI) state_nx = MEM;
          end
          OP_SLTI: begin
            bus.alu_op_o    = 3'd5;
            bus.alu_src_b_o = 2'd2;
            bus.keep_sign_o = 1'b1;
          end
          OP_ANDI, OP_ORI: begin
            bus.alu_op_o    = (op_q == OP_ANDI) ? 3'd3 : 3'd4;
            bus.alu_src_b_o = 2'd2;
          end
          OP_BEQ, OP_BNE: begin
            bus.alu_op_o   = 3'd1;
            bus.pc_src_o   = 2'd1;
            bus.pc_write_o = (op_q == OP_BEQ) ? bus.zero_i : !bus.zero_i;
            state_nx       = FETCH;
          end
          OP_J: begin
            bus.pc_src_o   = 2'd2;
            bus.pc_write_o = 1'b1;
            state_nx       = FETCH;
          end
          default: state_nx = FETCH;
        endcase
      end

      MEM: begin
        bus.mem_req_o = 1'b1;
        bus.iord_o    = 1'b1;
        bus.mem_we_o  = (op_q == OP_SW);
        if (bus.mem_ack_i) state_nx = (op_q == OP_SW) ? FETCH : WB;
      end

      WB: begin
        bus.reg_write_o  = 1'b1;
        bus.reg_dst_o    = (op_q == OP_R);
        bus.mem_to_reg_o = (op_q == OP_LW);
        state_nx         = FETCH;
      end

      HALT: state_nx = HALT;

      default: state_nx = IDLE;
    endcase
  end

  assign bus.illegal_o = illegal_q;
  assign bus.state_o   = ST_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a vector table walked cycle by cycle,
// followed by hand-written reset-in-MEM and HALT sequences.
module tb_multicycle_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  multicycle_ctrl_if #(.OP_W(6), .ST_W(3)) bus ();

  multicycle_ctrl #(.OP_W(6), .ST_W(3)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        ack;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  logic [19:0] act;
  assign act = {bus.state_o, bus.mem_req_o, bus.mem_we_o, bus.iord_o, bus.ir_write_o,
                bus.pc_write_o, bus.pc_src_o, bus.keep_sign_o, bus.alu_src_b_o,
                bus.alu_op_o, bus.reg_dst_o, bus.mem_to_reg_o, bus.reg_write_o,
                bus.illegal_o};

  function automatic logic [19:0] mk(
    input logic [2:0] st, input logic req, input logic we, input logic iord,
    input logic irw, input logic pcw, input logic [1:0] pcsrc, input logic ks,
    input logic [1:0] srcb, input logic [2:0] aluop, input logic rdst,
    input logic m2r, input logic rw, input logic ill);
    return {st, req, we, iord, irw, pcw, pcsrc, ks, srcb, aluop, rdst, m2r, rw, ill};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic a, input logic [19:0] e);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.ack = a; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then advance past the next edge.
  task automatic step(input logic r, input logic [5:0] op, input logic z,
                      input logic a, input logic [19:0] e, input string name);
    rst_i          = r;
    bus.instr_op_i = op;
    bus.zero_i     = z;
    bus.mem_ack_i  = a;
    #4;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h (state got %0d want %0d)",
               name, act, e, act[19:17], e[19:17]);
    end
    @(posedge clk_i);
    #1;
  endtask

  logic [19:0] IDLE0, FW, FA, DEC, EX_ANDI, EX_SX, EX_SLTI, EX_ORI, EX_R, EX_J;
  logic [19:0] BR_T, BR_N, MEM_RD, MEM_WR, WB_I, WB_R, WB_L, HALT_O;

  initial begin
    //             st req we io irw pcw src ks srcb op  rd m2r rw ill
    IDLE0   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    FW      = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    FA      = mk(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    DEC     = mk(2, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    EX_ANDI = mk(3, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0);
    EX_SX   = mk(3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    EX_SLTI = mk(3, 0, 0, 0, 0, 0, 0, 1, 2, 5, 0, 0, 0, 0);
    EX_ORI  = mk(3, 0, 0, 0, 0, 0, 0, 0, 2, 4, 0, 0, 0, 0);
    EX_R    = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    EX_J    = mk(3, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    BR_T    = mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    BR_N    = mk(3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    MEM_RD  = mk(4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MEM_WR  = mk(4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    WB_I    = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    WB_R    = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    WB_L    = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    HALT_O  = mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Opcode input is 63 outside DECODE so any use of it past DECODE shows up.
    add(1, 63, 0, 0, IDLE0);  add(0, 63, 0, 0, IDLE0);
    // andi, zero-wait
    add(0, 63, 0, 1, FA);     add(0, 12, 0, 0, DEC);
    add(0, 63, 1, 1, EX_ANDI); add(0, 63, 0, 1, WB_I);
    // lw: one fetch wait, MEM held 3 cycles
    add(0, 63, 0, 0, FW);     add(0, 63, 0, 1, FA);
    add(0, 35, 0, 0, DEC);    add(0, 63, 0, 0, EX_SX);
    add(0, 63, 0, 0, MEM_RD); add(0, 63, 0, 0, MEM_RD);
    add(0, 63, 0, 1, MEM_RD); add(0, 63, 0, 0, WB_L);
    // beq taken / not taken
    add(0, 63, 0, 1, FA);     add(0, 4, 0, 0, DEC);   add(0, 63, 1, 0, BR_T);
    add(0, 63, 0, 1, FA);     add(0, 4, 1, 0, DEC);   add(0, 63, 0, 0, BR_N);
    // R-type
    add(0, 63, 0, 1, FA);     add(0, 0, 0, 0, DEC);
    add(0, 63, 0, 0, EX_R);   add(0, 63, 0, 0, WB_R);
    // bne taken (zero=0), j
    add(0, 63, 0, 1, FA);     add(0, 5, 0, 0, DEC);   add(0, 63, 0, 0, BR_T);
    add(0, 63, 0, 1, FA);     add(0, 2, 0, 0, DEC);   add(0, 63, 0, 0, EX_J);
    // sw zero-wait
    add(0, 63, 0, 1, FA);     add(0, 43, 0, 0, DEC);
    add(0, 63, 0, 0, EX_SX);  add(0, 63, 0, 1, MEM_WR);
    // slti, ori, addi
    add(0, 63, 0, 1, FA);     add(0, 10, 0, 0, DEC);
    add(0, 63, 0, 0, EX_SLTI); add(0, 63, 0, 0, WB_I);
    add(0, 63, 0, 1, FA);     add(0, 13, 0, 0, DEC);
    add(0, 63, 0, 0, EX_ORI); add(0, 63, 0, 0, WB_I);
    add(0, 63, 0, 1, FA);     add(0, 8, 0, 0, DEC);
    add(0, 63, 0, 0, EX_SX);  add(0, 63, 0, 0, WB_I);

    bus.instr_op_i = 6'd0;
    bus.zero_i     = 1'b0;
    bus.mem_ack_i  = 1'b0;
    rst_i          = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].ack, vecs[i].exp,
           $sformatf("vec%0d", i));

    // sw interrupted by reset while its MEM request is still waiting
    step(0, 63, 0, 1, FA,     "t6_fetch");
    step(0, 43, 0, 0, DEC,    "t6_decode");
    step(0, 63, 0, 0, EX_SX,  "t6_exec");
    step(0, 63, 0, 0, MEM_WR, "t6_mem_wait");
    step(1, 63, 0, 1, MEM_WR, "t6_mem_rst");
    step(0, 63, 0, 1, IDLE0,  "t6_idle_after_rst");
    step(0, 63, 0, 0, FW,     "t6_refetch");

    // illegal opcode: HALT holds through acks and zero toggles until reset
    step(0, 63, 0, 1, FA,     "t5_fetch");
    step(0, 63, 0, 0, DEC,    "t5_decode");
    for (int k = 0; k < 10; k++)
      step(0, 63, k[0], 1, HALT_O, $sformatf("t5_halt%0d", k));
    step(1, 63, 0, 1, HALT_O, "t5_halt_rst");
    step(0, 63, 0, 0, IDLE0,  "t5_idle");
    step(0, 63, 0, 1, FA,     "t5_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
